// File: rtl/credit_mpi_sender.sv
// Multi-channel credit-flow-controlled sender: per-channel FIFOs, round-robin burst grant, valid/yumi output.
// Define CREDIT_MPI_SENDER_HDR_EN to precede each burst with a header flit {rnk[15:0], chan, L}.
module credit_mpi_sender #(
  parameter int DATA_W    = 64,
  parameter int RANK_W    = 32,
  parameter int CHANNELS  = 4,
  parameter int DEPTH     = 4,
  parameter int CREDITS   = 8,
  parameter int MAX_BURST = 4,
  localparam int CW = $clog2(CHANNELS),
  localparam int KW = $clog2(CREDITS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [RANK_W-1:0]            rnk,
  input  logic [CHANNELS-1:0]          in_valid,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  input  logic [CHANNELS*RANK_W-1:0]   in_dest,
  output logic [CHANNELS-1:0]          in_ready,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [RANK_W-1:0]            out_dest,
  output logic [CW-1:0]                out_chan,
  output logic                         out_hdr,
  input  logic                         out_yumi,
  input  logic                         credit_valid,
  input  logic [CW-1:0]                credit_chan,
  output logic [CHANNELS*KW-1:0]       credit_cnt,
  output logic                         credit_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(MAX_BURST + 1);

  // Output handshake: out_valid is a pure decode of the state register; a flit
  // transfers on any cycle where out_valid & out_yumi, and outputs hold otherwise.
`ifdef CREDIT_MPI_SENDER_HDR_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_DATA = 2'd2} state_t;
  if (DATA_W < 64) begin : g_data_w_check
    $error("credit_mpi_sender: DATA_W must be >= 64 when the header flit is enabled");
  end
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd2} state_t;
`endif

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem_data [CHANNELS][DEPTH];
  logic [RANK_W-1:0] mem_dest [CHANNELS][DEPTH];
  logic [AW-1:0]     rd_ptr   [CHANNELS];
  logic [AW-1:0]     wr_ptr   [CHANNELS];
  logic [OW-1:0]     occ      [CHANNELS];
  logic [KW-1:0]     cred     [CHANNELS];

  logic [CHANNELS-1:0] push, pop, elig, cred_inc;
  logic [CW-1:0]       chan_q, rr_q, grant_chan;
  logic [RANK_W-1:0]   dest_q;
  logic [LW-1:0]       len_q, rem_q, grant_len;
  logic                grant_found, load, credit_err_q;
  int                  sel_idx, gl;
  logic                unused_ok;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = (occ[i] != OW'(DEPTH));
      push[i]     = in_valid[i] & in_ready[i];
      pop[i]      = (state == S_DATA) & out_yumi & (chan_q == CW'(i));
      elig[i]     = (occ[i] != '0) & (cred[i] != '0);
      cred_inc[i] = credit_valid & (credit_chan == CW'(i));
      credit_cnt[i*KW +: KW] = cred[i];
    end
  end

  // Round-robin search starting at rr_q; burst length bounded by occupancy, credits and MAX_BURST.
  always_comb begin
    grant_found = 1'b0;
    grant_chan  = '0;
    sel_idx     = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      sel_idx = (int'(rr_q) + k) % CHANNELS;
      if (!grant_found && elig[sel_idx]) begin
        grant_found = 1'b1;
        grant_chan  = CW'(sel_idx);
      end
    end
    gl = MAX_BURST;
    if (int'(occ[grant_chan]) < gl)  gl = int'(occ[grant_chan]);
    if (int'(cred[grant_chan]) < gl) gl = int'(cred[grant_chan]);
    grant_len = LW'(gl);
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_found) begin
          load = 1'b1;
`ifdef CREDIT_MPI_SENDER_HDR_EN
          state_nxt = S_HDR;
`else
          state_nxt = S_DATA;
`endif
        end
      end
`ifdef CREDIT_MPI_SENDER_HDR_EN
      S_HDR:  if (out_yumi) state_nxt = S_DATA;
`endif
      S_DATA: if (out_yumi && rem_q == LW'(1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      chan_q <= '0;
      dest_q <= '0;
      len_q  <= '0;
      rem_q  <= '0;
      rr_q   <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        chan_q <= grant_chan;
        dest_q <= mem_dest[grant_chan][rd_ptr[grant_chan]];
        len_q  <= grant_len;
        rem_q  <= grant_len;
        rr_q   <= (grant_chan == CW'(CHANNELS - 1)) ? '0 : grant_chan + 1'b1;
      end else if (state == S_DATA && out_yumi) begin
        rem_q <= rem_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        occ[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
        if (pop[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        if (push[i] && !pop[i])      occ[i] <= occ[i] + 1'b1;
        else if (pop[i] && !push[i]) occ[i] <= occ[i] - 1'b1;
      end
    end
  end

  // Storage needs no reset: contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (push[i]) begin
        mem_data[i][wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
        mem_dest[i][wr_ptr[i]] <= in_dest[i*RANK_W +: RANK_W];
      end
    end
  end

  // A return and a data pop on the same channel cancel; a lone return at the cap is an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) cred[i] <= KW'(CREDITS);
      credit_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cred_inc[i] && !pop[i]) begin
          if (cred[i] == KW'(CREDITS)) credit_err_q <= 1'b1;
          else                         cred[i] <= cred[i] + 1'b1;
        end else if (pop[i] && !cred_inc[i]) begin
          cred[i] <= cred[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    case (state)
`ifdef CREDIT_MPI_SENDER_HDR_EN
      S_HDR:  out_data[63:0] = {rnk[15:0], 16'(chan_q), 32'(len_q)};
`endif
      S_DATA: out_data = mem_data[chan_q][rd_ptr[chan_q]];
      default: out_data = '0;
    endcase
  end

  assign out_valid  = (state != S_IDLE);
`ifdef CREDIT_MPI_SENDER_HDR_EN
  assign out_hdr    = (state == S_HDR);
`else
  assign out_hdr    = 1'b0;
`endif
  assign out_dest   = dest_q;
  assign out_chan   = chan_q;
  assign credit_err = credit_err_q;
  assign unused_ok  = ^{rnk, len_q};

endmodule
